shifter_2: RTL and testbench
============================

// Module: shifter_2
// PURPOSE
// - Fixed left-shift-by-2 unit for the MIPS datapath: branch offset / jump target word-to-byte scaling.
// - Output is a purely combinational copy of Input shifted left by SHAMT, zero-filled.
// - A registered copy (Output_q) with valid tracking feeds pipelined consumers.
// - Sits between the sign-extender / instruction-index field and the branch/jump target adders.
// PARAMETERS
// - WIDTH  32  data width of Input/Output/Output_q
// - SHAMT  2   constant left-shift amount; legal range 0..WIDTH-1
// PORTS
// - Clocking: one clock; reset is asynchronous and active-low.
// - clk       in   1      rising-edge clock
// - rst_n     in   1      asynchronous active-low reset
// - Input     in   WIDTH  operand to scale
// - in_valid  in   1      Input qualifies for capture into Output_q
// - Output    out  WIDTH  combinational result: Input << SHAMT
// - Output_q  out  WIDTH  registered Output, captured when in_valid=1
// - out_valid out  1      Output_q holds a captured value (1-cycle delayed in_valid)
// - ovf       out  1      present only with SHIFTER_2_OVF_EN: registered overflow flag
// BEHAVIOUR
// - Output = {Input[WIDTH-1-SHAMT:0], SHAMT'b0}, combinational, zero latency, no dependence on clk/rst_n.
// - Top SHAMT bits of Input are discarded. Logical shift only: no sign preservation; bit 31 of Output = Input[29].
// - SHAMT=0: Output = Input.
// - Reset (rst_n=0, async): Output_q=0, out_valid=0, ovf=0. Output keeps following Input during reset.
// - Each rising clk with rst_n=1:
//   - out_valid <= in_valid.
//   - If in_valid=1: Output_q <= Input << SHAMT.
//   - If in_valid=0: Output_q holds its previous value.
// - Latency: Output 0 cycles; Output_q/out_valid 1 cycle. Throughput one operand per cycle; no backpressure.
// - Reset deassertion mid-stream: first capture on the first rising edge after release.
// - Reset assertion mid-stream: registered state is cleared immediately, independent of clk.
// - No X propagation from reset: all flops have defined reset values.
// CONFIGURATION
// - SHIFTER_2_OVF_EN defined:
//   - Adds port ovf.
//   - ovf <= in_valid & |Input[WIDTH-1:WIDTH-SHAMT] on every clock, i.e. registered alongside Output_q.
//   - When in_valid=0, ovf <= 0.
//   - For SHAMT=0, ovf is tied to 0.
// - SHIFTER_2_OVF_EN undefined:
//   - No ovf port and no overflow logic.
//   - All other behaviour is identical.
// TESTING
// - Reset low, Input=0 -> Output=0, Output_q=0, out_valid=0, ovf=0.
// - Input=65 (0x41), no clock edge -> Output=260 (0x104) immediately; Output_q unchanged.
// - Input=234 (0xEA), in_valid=1, one clk -> Output=936 (0x3A8), Output_q=936, out_valid=1.
// - Input=0xC0000001, in_valid=1 -> Output=0x00000004; with SHIFTER_2_OVF_EN, ovf=1 after the edge.
// - in_valid=0 for 3 cycles while Input changes -> Output tracks Input; Output_q holds; out_valid=0.
// - Assert rst_n=0 between clock edges with Output_q=936 -> Output_q=0 and out_valid=0 without waiting for clk.

Source files
------------

// File: rtl/shifter_2.sv
// shifter_2: fixed left-shift-by-SHAMT scaler for branch offsets and jump targets.
// Output is the zero-latency shifted copy of Input. Output_q/out_valid give a
// registered copy for pipelined consumers.
// Optional feature macro: SHIFTER_2_OVF_EN adds a registered overflow flag (ovf)
// that is set when a captured operand had ones in the bits shifted out.
module shifter_2 #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHAMT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] Input,
    input  logic             in_valid,
    output logic [WIDTH-1:0] Output,
    output logic [WIDTH-1:0] Output_q,
    output logic             out_valid
`ifdef SHIFTER_2_OVF_EN
    ,
    output logic             ovf
`endif
);

    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;
    logic             valid_d;
    logic             valid_q;

    // Logical shift: the top SHAMT bits fall off and zeros enter at the bottom.
    // A shift (rather than a concatenation) keeps SHAMT=0 legal.
    assign shifted = Input << SHAMT;
    assign Output  = shifted;

    // Next-state for the capture register: load on in_valid, otherwise hold.
    always_comb begin
        data_d  = data_q;
        valid_d = in_valid;
        if (in_valid) begin
            data_d = shifted;
        end
    end

    // Capture register with asynchronous clear so reset takes effect between edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign Output_q  = data_q;
    assign out_valid = valid_q;

`ifdef SHIFTER_2_OVF_EN
    logic ovf_d;
    logic ovf_q;

    // Overflow means a captured operand lost a one from its discarded top bits.
    // With SHAMT=0 nothing is discarded, so the flag is constant zero.
    if (SHAMT > 0) begin : g_ovf
        always_comb begin
            ovf_d = in_valid & (|Input[WIDTH-1 -: SHAMT]);
        end
    end else begin : g_no_ovf
        always_comb begin
            ovf_d = 1'b0;
        end
    end

    // Overflow flag register, updated alongside Output_q on every edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_shifter_2.sv
// Directed self-checking bench for shifter_2 (WIDTH=32, SHAMT=2).
// Expected values are hand-computed constants.
module tb_shifter_2;

    localparam int unsigned WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] Input;
    logic             in_valid;
    logic [WIDTH-1:0] Output;
    logic [WIDTH-1:0] Output_q;
    logic             out_valid;
`ifdef SHIFTER_2_OVF_EN
    logic             ovf;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    shifter_2 #(.WIDTH(WIDTH), .SHAMT(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .Input    (Input),
        .in_valid (in_valid),
        .Output   (Output),
        .Output_q (Output_q),
        .out_valid(out_valid)
`ifdef SHIFTER_2_OVF_EN
        ,
        .ovf      (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] observed,
                         input logic [WIDTH-1:0] expected);
        n_tests++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, observed, expected);
        end
    endtask

    // Advance to the next rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        rst_n    = 1'b0;
        Input    = '0;
        in_valid = 1'b0;
        #2;
        check("rst_output",    Output,            32'h0);
        check("rst_output_q",  Output_q,          32'h0);
        check("rst_out_valid", {31'b0, out_valid}, 32'h0);
`ifdef SHIFTER_2_OVF_EN
        check("rst_ovf",       {31'b0, ovf},       32'h0);
`endif

        // Combinational path during reset, no edge needed
        Input = 32'd65;
        #1;
        check("comb_65",          Output,   32'd260);
        check("comb_65_q_steady", Output_q, 32'h0);

        // Release reset between edges, capture 234
        @(negedge clk);
        rst_n    = 1'b1;
        Input    = 32'd234;
        in_valid = 1'b1;
        #1;
        check("comb_234",        Output,   32'd936);
        check("pre_edge_q_zero", Output_q, 32'h0);
        step();
        check("cap_234_q",     Output_q,           32'd936);
        check("cap_234_valid", {31'b0, out_valid}, 32'h1);

        // Top bits discarded
        @(negedge clk);
        Input = 32'hC000_0001;
        #1;
        check("comb_c0000001", Output, 32'h0000_0004);
        step();
        check("cap_c0000001_q", Output_q, 32'h0000_0004);
`ifdef SHIFTER_2_OVF_EN
        check("ovf_set", {31'b0, ovf}, 32'h1);
`endif

        // in_valid low for three cycles: Output tracks, Output_q holds
        @(negedge clk);
        in_valid = 1'b0;
        Input    = 32'hFFFF_FFFF;
        #1;
        check("comb_all_ones", Output, 32'hFFFF_FFFC);
        step();
        check("hold1_q",     Output_q,           32'h0000_0004);
        check("hold1_valid", {31'b0, out_valid}, 32'h0);
`ifdef SHIFTER_2_OVF_EN
        check("ovf_clear_invalid", {31'b0, ovf}, 32'h0);
`endif
        @(negedge clk);
        Input = 32'h2000_0000;
        #1;
        check("comb_bit29_to_31", Output, 32'h8000_0000);
        step();
        check("hold2_q", Output_q, 32'h0000_0004);
        @(negedge clk);
        Input = 32'h8000_0000;
        #1;
        check("comb_no_sign_keep", Output, 32'h0);
        step();
        check("hold3_q",     Output_q,           32'h0000_0004);
        check("hold3_valid", {31'b0, out_valid}, 32'h0);

        // Capture a mixed pattern
        @(negedge clk);
        in_valid = 1'b1;
        Input    = 32'h1234_5678;
        #1;
        check("comb_12345678", Output, 32'h48D1_59E0);
        step();
        check("cap_12345678_q", Output_q, 32'h48D1_59E0);
`ifdef SHIFTER_2_OVF_EN
        check("ovf_none", {31'b0, ovf}, 32'h0);
`endif

        // Re-capture 936, then assert reset between edges
        @(negedge clk);
        Input = 32'd234;
        step();
        check("recap_234_q", Output_q, 32'd936);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_q",     Output_q,           32'h0);
        check("async_rst_valid", {31'b0, out_valid}, 32'h0);
        Input = 32'd7;
        #1;
        check("comb_in_reset", Output, 32'd28);

        // Release mid-stream: first capture on the first edge after release
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b1;
        Input    = 32'h0000_0003;
        #1;
        check("post_rel_pre_edge_q", Output_q, 32'h0);
        step();
        check("post_rel_cap_q",     Output_q,           32'h0000_000C);
        check("post_rel_cap_valid", {31'b0, out_valid}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
